// File: rtl/jump_ctrl.sv
// Branch decision for the CPU control path: combinational take-jump select,
// plus a registered copy of the qualified decision and saturating statistics.
module jump_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       opcode,
  input  logic [2:0]       status,
  input  logic             jmp_valid,
  output logic             jump,
  output logic             jump_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  logic             jump_q_q, jump_q_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  always_comb begin
    jump = 1'b1;
    unique case (opcode)
      2'b00: jump = 1'b1;
      2'b01: jump = status[0];
      2'b10: jump = status[1];
      2'b11: jump = status[2];
      default: jump = 1'b1;
    endcase
  end

  // Only one counter can move per cycle; each saturates at all ones.
  always_comb begin
    jump_q_d       = jmp_valid & jump;
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (jmp_valid) begin
      if (jump) begin
        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end else begin
        if (nottaken_cnt_q != '1) nottaken_cnt_d = nottaken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_q_q       <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      jump_q_q       <= jump_q_d;
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign jump_q       = jump_q_q;
  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: a wide-counter instance and a 2-bit
// counter instance share stimulus; a monitor pops expectations and compares.
module tb_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  opcode;
  logic [2:0]  status;
  logic        jmp_valid;

  logic        jump, jump_q;
  logic [15:0] taken_cnt, nottaken_cnt;
  logic        jump_s, jump_q_s;
  logic [1:0]  taken_cnt_s, nottaken_cnt_s;

  always #5 clk = ~clk;

  jump_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .status(status),
    .jmp_valid(jmp_valid), .jump(jump), .jump_q(jump_q),
    .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
  );

  jump_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .opcode(opcode), .status(status),
    .jmp_valid(jmp_valid), .jump(jump_s), .jump_q(jump_q_s),
    .taken_cnt(taken_cnt_s), .nottaken_cnt(nottaken_cnt_s)
  );

  typedef struct {
    string       name;
    logic        j;
    logic        jq;
    logic [15:0] t;
    logic [15:0] n;
    logic [1:0]  ts;
    logic [1:0]  ns;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  // Bench-side expectation state
  logic        e_jq;
  logic [15:0] e_t, e_n;
  logic [1:0]  e_ts, e_ns;

  function automatic logic jeq(input logic [1:0] op, input logic [2:0] st);
    if (op == 2'b00) return 1'b1;
    return st[op - 2'd1];
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, expv);
    end
  endtask

  // Monitor: compares whenever an expectation is presented
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      chk(e.name, "jump",         int'(jump),           int'(e.j));
      chk(e.name, "jump_sat",     int'(jump_s),         int'(e.j));
      chk(e.name, "jump_q",       int'(jump_q),         int'(e.jq));
      chk(e.name, "jump_q_sat",   int'(jump_q_s),       int'(e.jq));
      chk(e.name, "taken_cnt",    int'(taken_cnt),      int'(e.t));
      chk(e.name, "nottaken_cnt", int'(nottaken_cnt),   int'(e.n));
      chk(e.name, "taken_sat",    int'(taken_cnt_s),    int'(e.ts));
      chk(e.name, "nottaken_sat", int'(nottaken_cnt_s), int'(e.ns));
    end
  end

  task automatic push(input string nm, input logic j);
    exp_t e;
    e.name = nm; e.j = j; e.jq = e_jq;
    e.t = e_t; e.n = e_n; e.ts = e_ts; e.ns = e_ns;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    e_jq = 1'b0; e_t = '0; e_n = '0; e_ts = '0; e_ns = '0;
  endtask

  // Drive one cycle from the falling edge, update the model at the rising edge
  task automatic cyc(input string nm, input logic [1:0] op, input logic [2:0] st, input logic v);
    logic j;
    @(negedge clk);
    opcode = op; status = st; jmp_valid = v;
    j = jeq(op, st);
    @(posedge clk);
    e_jq = v & j;
    if (v && j) begin
      if (e_t != 16'hFFFF) e_t = e_t + 16'd1;
      if (e_ts != 2'b11)   e_ts = e_ts + 2'd1;
    end else if (v) begin
      if (e_n != 16'hFFFF) e_n = e_n + 16'd1;
      if (e_ns != 2'b11)   e_ns = e_ns + 2'd1;
    end
    #1 push(nm, j);
  endtask

  typedef struct { logic [1:0] op; logic [2:0] st; logic j; } vec_t;
  vec_t tt[8];

  initial begin
    tt[0] = '{2'b00, 3'b000, 1'b1}; tt[1] = '{2'b00, 3'b111, 1'b1};
    tt[2] = '{2'b01, 3'b001, 1'b1}; tt[3] = '{2'b01, 3'b110, 1'b0};
    tt[4] = '{2'b10, 3'b010, 1'b1}; tt[5] = '{2'b10, 3'b101, 1'b0};
    tt[6] = '{2'b11, 3'b100, 1'b1}; tt[7] = '{2'b11, 3'b011, 1'b0};

    rst = 1'b1; opcode = '0; status = '0; jmp_valid = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 8; i++) begin
      opcode = tt[i].op; status = tt[i].st;
      #1 push($sformatf("tt%0d", i), tt[i].j);
      #1;
    end
    for (int k = 0; k < 32; k++) begin
      logic [4:0] c;
      c = 5'(k);
      opcode = c[4:3]; status = c[2:0];
      #1 push($sformatf("sweep%0d", k), jeq(c[4:3], c[2:0]));
      #1;
    end

    @(negedge clk);
    rst = 1'b0;
    // Registered path: taken then not-taken
    cyc("reg_taken",    2'b01, 3'b001, 1'b1);  // jq=1 t=1 n=0
    cyc("reg_nottaken", 2'b01, 3'b000, 1'b1);  // jq=0 t=1 n=1
    cyc("reg_taken2",   2'b11, 3'b100, 1'b1);  // jq=1 t=2 n=1
    // Qualification: unconditional but not valid
    for (int i = 0; i < 5; i++) cyc($sformatf("qual%0d", i), 2'b00, 3'b000, 1'b0);

    // Asynchronous reset pulse between edges
    @(negedge clk);
    opcode = 2'b10; status = 3'b010;
    #1 rst = 1'b1;
    model_reset();
    #1 push("arst_a", 1'b1);
    #1 status = 3'b101;
    #1 push("arst_b", 1'b0);
    rst = 1'b0;

    // Saturation of the 2-bit instance
    for (int i = 0; i < 6; i++) cyc($sformatf("sat%0d", i), 2'b00, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) cyc($sformatf("satn%0d", i), 2'b01, 3'b110, 1'b1);

    for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    if (checks < 12) begin
      failures++;
      $display("FAIL check_count actual=%0d expected>=12", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
Branch-decision block for the CPU control path. It combines a 2-bit jump-type opcode with the 3-bit ALU status flags into a single combinational "take jump" signal, which drives the PC-load select. It also provides a registered copy of the decision and saturating taken/not-taken counters for the sequencer and debug logic.

Parameters:
CNT_W, 16, width of each jump statistics counter (minimum 1).

Ports:
clk  input  1  system clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
opcode  input  2  jump type: 00 unconditional, 01 on status[0], 10 on status[1], 11 on status[2].
status  input  3  ALU status flags, bit-indexed as listed for opcode.
jmp_valid  input  1  high when the current instruction is a jump; qualifies the registered outputs and counters.
jump  output  1  combinational jump decision.
jump_q  output  1  registered decision for the qualified jump.
taken_cnt  output  CNT_W  saturating count of qualified jumps that were taken.
nottaken_cnt  output  CNT_W  saturating count of qualified jumps that were not taken.

Behaviour:
- jump is purely combinational, with zero latency and no dependence on clk, rst or jmp_valid:
  - opcode 00: jump = 1 for any status value.
  - opcode 01: jump = status[0].
  - opcode 10: jump = status[1].
  - opcode 11: jump = status[2].
  - Status bits not selected by the opcode have no effect.
- No X-propagation special-casing; all 32 {opcode, status} combinations are fully defined as above.
- Reset (asynchronous, active-high):
  - When rst asserts, jump_q, taken_cnt and nottaken_cnt go to 0 immediately.
  - They hold at 0 while rst is high. jump keeps tracking its inputs during reset.
  - A mid-operation reset discards the counts.
- Each rising clk edge with rst low:
  - jump_q <= jmp_valid & jump. When jmp_valid = 0, jump_q becomes 0 on that edge.
  - If jmp_valid = 1 and jump = 1: taken_cnt increments by 1 unless it is all ones; then it holds (saturates, no wrap).
  - If jmp_valid = 1 and jump = 0: nottaken_cnt increments under the same saturation rule.
  - If jmp_valid = 0: both counters hold.
- Only one counter can change per cycle; there are no simultaneous-update conflicts.
- One-cycle latency from jmp_valid/opcode/status to jump_q and counter updates.
- Counter arithmetic is unsigned CNT_W bits. Saturation is detected by comparing against the all-ones value.
- No internal state beyond jump_q and the two counters; no state machine.

Test Plan:
- Combinational truth table, each pair checked 1 time unit after applying inputs with rst held high:
  - {opcode,status} = 00_000 -> jump=1; 00_111 -> jump=1.
  - 01_001 -> jump=1; 01_110 -> jump=0.
  - 10_010 -> jump=1; 10_101 -> jump=0.
  - 11_100 -> jump=1; 11_011 -> jump=0.
  - Also sweep all 32 combinations against the equation.
- Registered path: rst low; opcode=01, status=001, jmp_valid=1 for one edge -> jump_q=1, taken_cnt=1, nottaken_cnt=0. Then status=000 for one edge -> jump_q=0, nottaken_cnt=1.
- Qualification: jmp_valid=0 with opcode=00 for 5 edges -> jump=1 throughout, jump_q=0, both counters unchanged.
- Saturation: CNT_W=2, opcode=00, jmp_valid=1 for 6 edges -> taken_cnt steps 1,2,3,3,3,3; nottaken_cnt stays 0.
- Asynchronous reset: after counts reach nonzero values, pulse rst between clock edges -> jump_q, taken_cnt and nottaken_cnt read 0 before the next edge. jump continues to follow the opcode/status inputs during the pulse.
